// File: rtl/gups_pkg.sv
// Shared encodings and constants for the GUPS update engine.
package gups_pkg;

  typedef enum logic [1:0] {
    MODE_INC  = 2'd0,
    MODE_XOR  = 2'd1,
    MODE_RD   = 2'd2,
    MODE_INC3 = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GEN  = 3'd1,
    ST_RD   = 3'd2,
    ST_MOD  = 3'd3,
    ST_WR   = 3'd4,
    ST_NEXT = 3'd5,
    ST_FIN  = 3'd6
  } state_e;

  // Galois right-shift taps.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  // All-zero is the LFSR lock state, so a zero seed loads as this value.
  localparam logic [15:0] ZERO_SEED_SUB = 16'h0001;

endpackage

// File: rtl/gups_lfsr.sv
// One Galois LFSR address stream with seed load and advance enables.
module gups_lfsr import gups_pkg::*; #(
  parameter int unsigned     LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] seed_eff;

  assign seed_eff = (seed == '0) ? LFSR_W'(ZERO_SEED_SUB) : seed;

  // Load has priority; advance steps the register once per completed update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= '0;
    end else if (load) begin
      value <= seed_eff;
    end else if (advance) begin
      value <= (value >> 1) ^ (value[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/gups_update_engine.sv
// Round-robin multi-lane read-modify-write update engine over a req/rdy memory port.
module gups_update_engine import gups_pkg::*; #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LANES  = 4,
  parameter int unsigned LFSR_W = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_updates,
  input  logic [1:0]              mode,
  input  logic [LANES*LFSR_W-1:0] seed,
  input  logic [ADDR_W-1:0]       range,
  output logic [ADDR_W-1:0]       addr,
  output logic [DATA_W-1:0]       dout,
  input  logic [DATA_W-1:0]       din,
  output logic                    req,
  output logic                    wr,
  input  logic                    rdy,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        upd_count
);

  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_e             state;
  state_e             state_d;
  mode_e              mode_q;
  logic [CNT_W-1:0]   num_q;
  logic [ADDR_W-1:0]  range_q;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  mod_data;
  logic [LANE_W-1:0]  lane;
  logic [LFSR_W-1:0]  lfsr_val [LANES];
  logic [LFSR_W-1:0]  cur_lfsr;
  logic [LANES-1:0]   adv;
  logic               load;

  assign load     = (state == ST_IDLE) && start;
  assign cur_lfsr = lfsr_val[lane];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign adv[i] = (state == ST_NEXT) && (lane == LANE_W'(i));

    gups_lfsr #(
      .LFSR_W (LFSR_W),
      .TAPS   (LFSR_W'(LFSR_TAPS))
    ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .advance (adv[i]),
      .seed    (seed[i*LFSR_W +: LFSR_W]),
      .value   (lfsr_val[i])
    );
  end

  // Modified word: xor with the lane LFSR in xor mode, otherwise wrapping increment.
  always_comb begin
    mod_data = data_q + DATA_W'(1);
    if (mode_q == MODE_XOR) begin
      mod_data = data_q ^ DATA_W'(cur_lfsr);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode; rdy only matters while a request is outstanding.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (start) state_d = ST_GEN;
      ST_GEN:  state_d = (upd_count == num_q) ? ST_FIN : ST_RD;
      ST_RD:   if (rdy) state_d = ST_MOD;
      ST_MOD:  state_d = (mode_q == MODE_RD) ? ST_NEXT : ST_WR;
      ST_WR:   if (rdy) state_d = ST_NEXT;
      ST_NEXT: state_d = ST_GEN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs, run configuration and datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req       <= 1'b0;
      wr        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr      <= '0;
      dout      <= '0;
      upd_count <= '0;
      lane      <= '0;
      num_q     <= '0;
      mode_q    <= MODE_INC;
      range_q   <= '0;
      data_q    <= '0;
    end else begin
      req  <= (state_d == ST_RD) || (state_d == ST_WR);
      wr   <= (state_d == ST_WR);
      busy <= (state_d != ST_IDLE);
      done <= (state_d == ST_FIN);
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_q     <= num_updates;
            mode_q    <= mode_e'(mode);
            range_q   <= range;
            upd_count <= '0;
            lane      <= '0;
          end
        end
        ST_GEN: begin
          if (upd_count != num_q) begin
            addr <= ADDR_W'(cur_lfsr) & range_q;
          end
        end
        ST_RD: begin
          if (rdy) begin
            data_q <= din;
          end
        end
        ST_MOD: begin
          if (mode_q != MODE_RD) begin
            dout <= mod_data;
          end
        end
        ST_NEXT: begin
          upd_count <= upd_count + CNT_W'(1);
          lane      <= (lane == LANE_W'(LANES - 1)) ? '0 : lane + LANE_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gups_update_engine.md
Name: gups_update_engine

Overview:
Parametrised random-access update engine. It is the successor to the single-stream GUPS core.
- LANES independent 16-bit LFSR address streams, served round-robin.
- Each update reads a word, modifies it by mode, and writes it back over the existing req/wr/rdy memory handshake.
- A start/done controller runs a programmable update count.
- Sits between the host control registers and the memory adapter.

Parameters:
DATA_W, 64, memory word width
ADDR_W, 64, address width
LANES, 4, number of LFSR address streams (1..16)
LFSR_W, 16, LFSR width per lane
CNT_W, 32, update counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse; sampled only in IDLE
num_updates  in  CNT_W  total updates to perform
mode  in  2  0=increment, 1=xor with lane LFSR value (zero-extended), 2=read-only, 3=treated as 0
seed  in  LANES*LFSR_W  lane i seed at [i*LFSR_W +: LFSR_W]
range  in  ADDR_W  address mask
addr  out  ADDR_W  memory address
dout  out  DATA_W  write data
din  in  DATA_W  read data, valid in the rdy cycle of a read
req  out  1  request
wr  out  1  1=write, 0=read; valid while req=1
rdy  in  1  single-cycle completion pulse from memory
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse when the run finishes
upd_count  out  CNT_W  updates completed in the current/last run

Behaviour:
- Reset (rst=0 at an edge) values:
  - FSM=IDLE; req, wr, busy, done = 0; addr, dout = 0.
  - upd_count=0; lane pointer=0; LFSRs=0.
  - Reset mid-transaction abandons it immediately; memory must tolerate req dropping.
- start in IDLE latches num_updates, mode, range and seed; busy=1 the next cycle.
  - A zero seed is loaded as 1 (zero is an LFSR lock state).
  - upd_count and lane pointer clear at start.
  - start outside IDLE is ignored.
- LFSR: Galois, right-shift, taps 16'hB400. next = (s>>1) ^ (s[0] ? 16'hB400 : 0). A lane advances only after its update completes.
- Address: current lane LFSR value zero-extended to ADDR_W, AND range.
- FSM:
  - IDLE: on start -> GEN.
  - GEN: if upd_count==num_updates -> FIN; else latch addr from the current lane -> RD.
  - RD: req=1, wr=0, addr held; on rdy capture din -> MOD; rdy while req=0 is ignored.
  - MOD:
    - mode0/3: dout=data+1, modulo 2^DATA_W, wraps all-ones to 0.
    - mode1: dout=data ^ lfsr.
    - -> WR, or -> NEXT in mode2.
  - WR: req=1, wr=1, addr/dout held until rdy -> NEXT.
  - NEXT: req=0; upd_count+1; current lane LFSR advances; lane pointer = (lane+1) mod LANES -> GEN.
  - FIN: done=1 for one cycle; busy=0 next cycle -> IDLE.
- req drops the cycle after rdy. Minimum of one idle req cycle between transactions.
- addr, wr and dout are stable for the whole time req=1.
- num_updates=0: start -> GEN -> FIN, with no request issued.
- upd_count holds its final value in IDLE until the next start.

Decomposition:
- Shared package/header gups_pkg:
  - mode encodings;
  - FSM state encodings;
  - LFSR tap constant 16'hB400;
  - zero-seed substitute value.
- Sub-module gups_lfsr (LFSR_W, taps, load/advance enables), instantiated LANES times via generate.

Test Plan:
1. LANES=1, seed=16'h1234, range=64'h1fff, mode=0, num_updates=1, memory returns din=5 → read at addr 0x1234, then write at 0x1234 with dout=6; done pulses; upd_count=1.
2. seed=16'h0001, num_updates=2 → second address is 0xB400&range. seed=0 → first address 0x0001.
3. LANES=4, seeds 0x0011/0x0022/0x0033/0x0044, mode=2, num_updates=4 → reads at 0x11, 0x22, 0x33, 0x44 in order; no writes issued.
4. mode=0, din=64'hFFFF_FFFF_FFFF_FFFF → dout=0. mode=1, seed 0x00F0, din=0x0F → dout=0xFF.
5. num_updates=0 → req never asserts; done pulses within 3 cycles of start. A second start while busy is ignored, so upd_count equals the first run's num_updates.
6. rdy delayed 7 cycles, plus a spurious rdy with req=0, plus rst=0 pulsed during WR → addr/dout held while waiting; the spurious rdy is ignored; after the reset all outputs are 0 and the FSM is in IDLE.
